// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for the instruction-fetch and data load/store streams.
// Data has priority over instruction fetch, with a starvation guard and a RAM timeout.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] IGRANT  = 3'd1;
    localparam logic [2:0] DRGRANT = 3'd2;
    localparam logic [2:0] DWGRANT = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT);

    logic [2:0] state;
    logic [3:0] starve_cnt;
    logic [7:0] timeout_cnt;
    logic       resp_data;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Strobes and wait pulses decode straight from the state register, so an
    // asynchronous reset drops them in the same cycle.
    assign ramREN = (state == IGRANT) || (state == DRGRANT);
    assign ramWEN = (state == DWGRANT);
    assign iwait  = !((state == RESP) && !resp_data);
    assign dwait  = !((state == RESP) && resp_data);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            timeout_cnt <= '0;
            resp_data   <= 1'b0;
            ramaddr     <= '0;
            ramstore    <= '0;
            iload       <= '0;
            dload       <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iREN && (starve_cnt == STARVE_MAX)) begin
                        state      <= IGRANT;
                        ramaddr    <= iaddr;
                        resp_data  <= 1'b0;
                        starve_cnt <= '0;
                    end else if (dWEN || dREN) begin
                        state      <= dWEN ? DWGRANT : DRGRANT;
                        ramaddr    <= daddr;
                        resp_data  <= 1'b1;
                        starve_cnt <= iREN ? sat_inc(starve_cnt) : 4'd0;
                        if (dWEN) begin
                            ramstore <= dstore;
                        end
                    end else if (iREN) begin
                        state      <= IGRANT;
                        ramaddr    <= iaddr;
                        resp_data  <= 1'b0;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                IGRANT, DRGRANT, DWGRANT: begin
                    if (ramstate == RAM_ACCESS) begin
                        if (state == IGRANT) begin
                            iload <= ramload;
                        end
                        if (state == DRGRANT) begin
                            dload <= ramload;
                        end
                        state       <= RESP;
                        timeout_cnt <= '0;
                    end else if (ramstate == RAM_ERROR) begin
                        // Release the requestor anyway; the loads keep their old value.
                        err         <= 1'b1;
                        state       <= RESP;
                        timeout_cnt <= '0;
                    end else if (timeout_cnt + 8'd1 == TIMEOUT_MAX) begin
                        err         <= 1'b1;
                        state       <= RESP;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a latency-programmable RAM responder plus
// a shadow memory and grant-order model that predict every observable result.
`timescale 1ns/1ps
module tb_memory_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = 2'd0;

    int checks = 0;
    int errors = 0;

    // RAM responder controls: mode 0 = ACCESS on grant cycle ram_lat, 1 = stuck BUSY, 2 = ERROR on ram_lat
    int ram_lat  = 1;
    int ram_mode = 0;
    int ramcyc   = 0;
    bit mem_init = 1'b0;
    logic [31:0] mem_ram [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_iload = '0;
    logic [31:0] exp_dload = '0;

    memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 16) return 32'h8C22_0004;
        return 32'h1000_0000 + 32'(idx) * 32'h0001_0203;
    endfunction

    always @(posedge CLK) begin
        #2;
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem_ram[i] = init_word(i);
            mem_init = 1'b1;
        end
        if (ramREN || ramWEN) begin
            ramcyc = ramcyc + 1;
            if (ram_mode != 1 && ramcyc == ram_lat) begin
                ramstate = (ram_mode == 2) ? 2'd3 : 2'd2;
                ramload  = (ram_mode == 2) ? $urandom : mem_ram[ramaddr[7:2]];
                if (ramWEN && ram_mode == 0) mem_ram[ramaddr[7:2]] = ramstore;
            end else begin
                ramstate = 2'd1;
                ramload  = $urandom;
            end
        end else begin
            ramcyc   = 0;
            ramstate = 2'd0;
            ramload  = $urandom;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick;
        tick;
        checks++;
        if (iwait !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0 || err !== 1'b0 ||
            iload !== 32'h0 || dload !== 32'h0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            errors++;
            $display("FAIL reset: iwait=%b dwait=%b ramREN=%b ramWEN=%b err=%b iload=%h dload=%h ramaddr=%h ramstore=%h, want 1 1 0 0 0 and all zero",
                     iwait, dwait, ramREN, ramWEN, err, iload, dload, ramaddr, ramstore);
        end
        RST = 1'b0;
        tick;
        checks++;
        if (iwait !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: iwait=%b dwait=%b ramREN=%b ramWEN=%b, want 1 1 0 0", iwait, dwait, ramREN, ramWEN);
        end
    endtask

    task automatic test_ifetch;
        iREN = 1'b1; iaddr = 32'h40; ram_mode = 0; ram_lat = 2;
        for (int c = 1; c <= 2; c++) begin
            tick;
            checks++;
            if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
                errors++;
                $display("FAIL ifetch_grant c=%0d: ramREN=%b ramWEN=%b ramaddr=%h iwait=%b, want 1 0 00000040 1", c, ramREN, ramWEN, ramaddr, iwait);
            end
        end
        tick;
        exp_iload = 32'h8C22_0004;
        checks++;
        if (iwait !== 1'b0 || dwait !== 1'b1 || ramREN !== 1'b0 || iload !== exp_iload) begin
            errors++;
            $display("FAIL ifetch_resp: iwait=%b dwait=%b ramREN=%b iload=%h, want 0 1 0 %h", iwait, dwait, ramREN, iload, exp_iload);
        end
        iREN = 1'b0;
        tick;
        checks++;
        if (iwait !== 1'b1 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL ifetch_idle: iwait=%b ramREN=%b, want 1 0", iwait, ramREN);
        end
    endtask

    task automatic test_priority;
        dWEN = 1'b1; dREN = 1'b1; iREN = 1'b1;
        daddr = 32'h100; dstore = 32'hDEAD_BEEF; iaddr = 32'h100;
        ram_mode = 0; ram_lat = 1;
        tick;
        checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL prio_write_grant: ramWEN=%b ramREN=%b ramaddr=%h ramstore=%h, want 1 0 00000100 deadbeef", ramWEN, ramREN, ramaddr, ramstore);
        end
        ref_mem[0] = 32'hDEAD_BEEF;
        tick;
        checks++;
        if (dwait !== 1'b0 || iwait !== 1'b1 || ramWEN !== 1'b0 || dload !== exp_dload) begin
            errors++;
            $display("FAIL prio_dwait: dwait=%b iwait=%b ramWEN=%b dload=%h, want 0 1 0 %h", dwait, iwait, ramWEN, dload, exp_dload);
        end
        dWEN = 1'b0; dREN = 1'b0;
        tick;
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL prio_idle_gap: ramREN=%b ramWEN=%b iwait=%b dwait=%b, want 0 0 1 1", ramREN, ramWEN, iwait, dwait);
        end
        tick;
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100) begin
            errors++;
            $display("FAIL prio_inst_grant: ramREN=%b ramWEN=%b ramaddr=%h, want 1 0 00000100", ramREN, ramWEN, ramaddr);
        end
        tick;
        exp_iload = ref_mem[0];
        checks++;
        if (iwait !== 1'b0 || dwait !== 1'b1 || iload !== exp_iload) begin
            errors++;
            $display("FAIL prio_inst_resp: iwait=%b dwait=%b iload=%h, want 0 1 %h", iwait, dwait, iload, exp_iload);
        end
        iREN = 1'b0;
        tick;
    endtask

    task automatic test_random;
        int kind, idx, lat;
        logic [31:0] addr, wd;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(0, 63);
            lat  = $urandom_range(1, 5);
            wd   = $urandom;
            addr = {24'h0, idx[5:0], 2'b00};
            ram_mode = 0; ram_lat = lat;
            case (kind)
                0: begin iREN = 1'b1; iaddr = addr; end
                1: begin dREN = 1'b1; daddr = addr; end
                default: begin dWEN = 1'b1; dREN = 1'($urandom_range(0, 1)); daddr = addr; dstore = wd; end
            endcase
            for (int c = 1; c <= lat; c++) begin
                tick;
                checks++;
                if (ramREN !== (kind != 2) || ramWEN !== (kind == 2) || ramaddr !== addr ||
                    (kind == 2 && ramstore !== wd) || iwait !== 1'b1 || dwait !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_grant n=%0d c=%0d: ramREN=%b ramWEN=%b ramaddr=%h ramstore=%h iwait=%b dwait=%b, want kind=%0d addr=%h data=%h waits high",
                             n, c, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, kind, addr, wd);
                end
            end
            tick;
            case (kind)
                0: exp_iload = ref_mem[idx];
                1: exp_dload = ref_mem[idx];
                default: ref_mem[idx] = wd;
            endcase
            checks++;
            if (iwait !== (kind != 0) || dwait !== (kind == 0) || ramREN !== 1'b0 || ramWEN !== 1'b0 ||
                iload !== exp_iload || dload !== exp_dload) begin
                errors++;
                $display("FAIL rnd_resp n=%0d kind=%0d: iwait=%b dwait=%b ramREN=%b ramWEN=%b iload=%h dload=%h, want iload=%h dload=%h",
                         n, kind, iwait, dwait, ramREN, ramWEN, iload, dload, exp_iload, exp_dload);
            end
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            tick;
            checks++;
            if (iwait !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
                errors++;
                $display("FAIL rnd_idle n=%0d: iwait=%b dwait=%b ramREN=%b ramWEN=%b, want 1 1 0 0", n, iwait, dwait, ramREN, ramWEN);
            end
        end
    endtask

    task automatic test_starvation;
        int  run;
        bit  exp_inst, got_inst;
        iREN = 1'b1; iaddr = 32'hC0; dREN = 1'b1; daddr = 32'hC4;
        ram_mode = 0; ram_lat = 1;
        run = 0;
        for (int g = 0; g < 10; g++) begin
            exp_inst = (run == STARVE_LIMIT);
            run = exp_inst ? 0 : run + 1;
            tick;
            got_inst = (ramaddr === iaddr);
            checks++;
            if (ramREN !== 1'b1 || got_inst !== exp_inst) begin
                errors++;
                $display("FAIL starve_order g=%0d: ramREN=%b instruction_grant=%b ramaddr=%h, want 1 %b", g, ramREN, got_inst, ramaddr, exp_inst);
            end
            tick;
            if (exp_inst) exp_iload = ref_mem[48];
            else          exp_dload = ref_mem[49];
            checks++;
            if (iwait !== !exp_inst || dwait !== exp_inst || iload !== exp_iload || dload !== exp_dload) begin
                errors++;
                $display("FAIL starve_resp g=%0d: iwait=%b dwait=%b iload=%h dload=%h, want %b %b %h %h",
                         g, iwait, dwait, iload, dload, !exp_inst, exp_inst, exp_iload, exp_dload);
            end
            tick;
        end
        iREN = 1'b0; dREN = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_before_timeout: err=%b, want 0", err);
        end
        dREN = 1'b1; daddr = 32'h80; ram_mode = 1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick;
            checks++;
            if (ramREN !== 1'b1 || dwait !== 1'b1 || ramaddr !== 32'h80) begin
                errors++;
                $display("FAIL timeout_grant c=%0d: ramREN=%b dwait=%b ramaddr=%h, want 1 1 00000080", c, ramREN, dwait, ramaddr);
            end
        end
        tick;
        checks++;
        if (dwait !== 1'b0 || iwait !== 1'b1 || err !== 1'b1 || ramREN !== 1'b0 || dload !== exp_dload) begin
            errors++;
            $display("FAIL timeout_resp: dwait=%b iwait=%b err=%b ramREN=%b dload=%h, want 0 1 1 0 %h", dwait, iwait, err, ramREN, dload, exp_dload);
        end
        dREN = 1'b0; ram_mode = 0;
        tick;
        checks++;
        if (dwait !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_single_pulse: dwait=%b err=%b, want 1 1", dwait, err);
        end
        dREN = 1'b1; daddr = 32'h84; ram_lat = 1;
        tick;
        tick;
        exp_dload = ref_mem[33];
        checks++;
        if (dwait !== 1'b0 || err !== 1'b1 || dload !== exp_dload) begin
            errors++;
            $display("FAIL err_sticky: dwait=%b err=%b dload=%h, want 0 1 %h", dwait, err, dload, exp_dload);
        end
        dREN = 1'b0;
        tick;
    endtask

    task automatic test_error_reset;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        exp_iload = '0; exp_dload = '0;
        tick;
        checks++;
        if (err !== 1'b0 || iload !== 32'h0 || dload !== 32'h0) begin
            errors++;
            $display("FAIL err_cleared_by_reset: err=%b iload=%h dload=%h, want 0 0 0", err, iload, dload);
        end
        iREN = 1'b1; iaddr = 32'h44; ram_mode = 2; ram_lat = 2;
        tick;
        tick;
        tick;
        checks++;
        if (iwait !== 1'b0 || dwait !== 1'b1 || err !== 1'b1 || iload !== exp_iload) begin
            errors++;
            $display("FAIL ram_error_resp: iwait=%b dwait=%b err=%b iload=%h, want 0 1 1 %h", iwait, dwait, err, iload, exp_iload);
        end
        iREN = 1'b0; ram_mode = 0;
        tick;
        checks++;
        if (iwait !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL ram_error_after: iwait=%b err=%b, want 1 1", iwait, err);
        end
        dREN = 1'b1; daddr = 32'h88; ram_mode = 1;
        tick;
        tick;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h88) begin
            errors++;
            $display("FAIL pre_reset_grant: ramREN=%b ramaddr=%h, want 1 00000088", ramREN, ramaddr);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0 || iwait !== 1'b1 ||
            dwait !== 1'b1 || err !== 1'b0 || iload !== 32'h0 || dload !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ramREN=%b ramWEN=%b ramaddr=%h ramstore=%h iwait=%b dwait=%b err=%b iload=%h dload=%h, want reset values",
                     ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, err, iload, dload);
        end
        dREN = 1'b0; ram_mode = 0;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if (dwait !== 1'b1 || iwait !== 1'b1 || ramREN !== 1'b0) begin
                errors++;
                $display("FAIL no_pulse_after_reset c=%0d: dwait=%b iwait=%b ramREN=%b, want 1 1 0", c, dwait, iwait, ramREN);
            end
            if (c == 1) RST = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        test_reset;
        test_ifetch;
        test_priority;
        test_random;
        test_starvation;
        test_timeout;
        test_error_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port RAM arbiter that services the datapath's two memory request streams: instruction fetch, and the data read/write strobes the control unit decodes from LW/SW. It grants one requestor at a time, holds a stable request on the RAM until the RAM reports ACCESS, and returns the read word with a one-cycle wait-release handshake. It enforces data-over-instruction priority with a starvation guard and a RAM timeout. It sits between the datapath/cache side and the RAM model.

## Interface
- STARVE_LIMIT, 4: maximum consecutive data grants while iREN is pending before one instruction grant is forced (range 1–15).
- TIMEOUT, 255: maximum cycles in a grant state without ACCESS before the access is aborted (range 1–255).

- CLK  in  1  system clock; everything is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request. Held until iwait is observed low.
- iaddr  in  32  instruction word address.
- iwait  out  1  0 for exactly one cycle when iload is valid. 1 otherwise.
- iload  out  32  registered instruction word.
- dREN  in  1  data read request. Held until dwait is observed low.
- dWEN  in  1  data write request. If dREN and dWEN are both 1, dWEN wins.
- daddr  in  32  data word address.
- dstore  in  32  write data.
- dwait  out  1  0 for exactly one cycle on data completion. 1 otherwise.
- dload  out  32  registered data read word.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate==ACCESS.
- ramstate  in  2  ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky error flag, set on RAM ERROR or timeout. Cleared only by reset.

## Operation
- FSM states: IDLE, IGRANT, DRGRANT, DWGRANT, RESP.
- **IDLE:**
  - Sample the requests at the clock edge, in priority order:
    1. dWEN → DWGRANT.
    2. dREN → DRGRANT.
    3. iREN → IGRANT.
    4. Nothing pending → stay in IDLE.
  - Starvation override: if iREN=1 and the starve counter equals STARVE_LIMIT, go to IGRANT regardless of data requests.
  - On entering any grant state, latch the address, and dstore for writes, into internal registers. RAM outputs are driven from these registers, so ramaddr and ramstore are stable for the whole grant.
- **Grant states:**
  - Strobe outputs: ramREN=1 in IGRANT and DRGRANT. ramWEN=1 in DWGRANT.
  - ramstate==ACCESS:
    - Capture ramload into iload (IGRANT) or dload (DRGRANT). DWGRANT leaves dload unchanged.
    - Record the completing port, clear the timeout counter, and go to RESP.
  - ramstate==ERROR: set err. Still go to RESP, with iload/dload unchanged, so the requestor is released.
  - ramstate FREE/BUSY: increment the timeout counter. When it reaches TIMEOUT, set err and go to RESP.
- **RESP:**
  - All RAM strobes are 0.
  - The recorded port's wait output is 0 for this single cycle.
  - Next state is IDLE.
- **Starve counter (4 bits):**
  - Increments on each data grant issued while iREN=1, saturating at 15.
  - Clears on any instruction grant, and on any IDLE cycle with iREN=0.
- Requests that drop during a grant do not abort the RAM access. The access completes and the wait pulse is issued anyway.

## Timing
- **Reset values:**
  - state=IDLE, iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - err=0, all counters 0.
- Reset asserted mid-grant drops the RAM strobes immediately (asynchronously). No wait pulse is issued.
- **Latency** (request first visible in cycle 0):
  - Cycle 1: grant; RAM strobe high.
  - First ACCESS cycle k≥1: data captured at the end of cycle k.
  - Cycle k+1: wait=0.
  - Cycle k+2: IDLE.
- Minimum turnaround is 3 cycles per access. No back-to-back grants without an IDLE cycle.
- The RAM strobes and ramaddr never change in the middle of a grant.
- iwait and dwait are never low in the same cycle.

## Test plan
- **Instruction fetch:** iREN=1, iaddr=0x40, RAM gives ACCESS in cycle 2 with ramload=0x8C220004 → ramREN high in cycles 1–2; iwait=0 only in cycle 3; iload=0x8C220004.
- **Priority and write path:** dWEN=1 and dREN=1 and iREN=1 together, daddr=0x100, dstore=0xDEADBEEF → DWGRANT, with ramWEN=1, ramREN=0, ramstore=0xDEADBEEF. The dwait pulse comes first. The instruction is granted after the next IDLE, once the data requests have dropped.
- **Starvation:** dREN held continuously with iREN=1, STARVE_LIMIT=4, RAM giving ACCESS in 1 cycle → exactly 4 data grants, then 1 instruction grant, then data resumes.
- **Timeout:** TIMEOUT=8, RAM stuck BUSY on a dREN → RESP after 8 grant cycles; dwait pulses once; err=1 and stays 1; dload unchanged.
- **ERROR and reset:** ramstate=ERROR during IGRANT → err=1 and an iwait pulse. Then RST asserted mid-grant on a later access → all outputs at reset values in the same cycle, and no wait pulse.
